// File: rtl/cpu_debug_scan_master.sv
// cpu_debug_scan_master
// Initiator side of the 2-bit-IR virtual-JTAG debug link. Each accepted command
// runs one scan: IR update, DR capture, DR shift (LSB first), DR update, then
// RTI_CYCLES idle TCK periods. After that the captured TDO word is offered as a
// response.
// Optional feature: define DEBUG_SCAN_IR_CAPTURE_EN to register vji_ir_out on the
// rising TCK in UIR and present it on rsp_ir_out. Without it rsp_ir_out is 0.
// DR_WIDTH must be at least 2, and TCK_DIV and RTI_CYCLES at least 1.

module cpu_debug_scan_master #(
  parameter int DR_WIDTH   = 38,
  parameter int IR_WIDTH   = 2,
  parameter int TCK_DIV    = 4,
  parameter int RTI_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

  localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam int SH_W  = $clog2(DR_WIDTH + 1);
  localparam int RTI_W = $clog2(RTI_CYCLES + 1);

  // LOAD is a single clk between the handshake and UIR, so the first TCK period
  // starts from a freshly cleared divider.
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_UIR, S_CDR, S_SHIFT, S_UDR, S_RTI, S_RESP
  } state_t;

  state_t               state, state_next;
  logic [DIV_W-1:0]     div_cnt;
  logic                 tck_q;
  logic [SH_W-1:0]      bit_cnt;
  logic [RTI_W-1:0]     rti_cnt;
  logic [DR_WIDTH-1:0]  data_sr;
  logic [DR_WIDTH-1:0]  cap_sr;
  logic [IR_WIDTH-1:0]  ir_q;
  logic                 busy;
  logic                 half_end;
  logic                 tck_rise;
  logic                 period_end;
  logic                 accept;

  // TCK phase decode: a period ends on the edge where tck drops back to 0.
  always_comb begin
    busy       = (state == S_UIR) || (state == S_CDR) || (state == S_SHIFT) ||
                 (state == S_UDR) || (state == S_RTI);
    half_end   = busy && (div_cnt == DIV_W'(TCK_DIV - 1));
    tck_rise   = half_end && !tck_q;
    period_end = half_end && tck_q;
    accept     = (state == S_IDLE) && cmd_valid;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state logic: scan states advance only at the end of a TCK period.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (cmd_valid) state_next = S_LOAD;
      S_LOAD:  state_next = S_UIR;
      S_UIR:   if (period_end) state_next = S_CDR;
      S_CDR:   if (period_end) state_next = S_SHIFT;
      S_SHIFT: if (period_end && bit_cnt == SH_W'(DR_WIDTH - 1)) state_next = S_UDR;
      S_UDR:   if (period_end) state_next = S_RTI;
      S_RTI:   if (period_end && rti_cnt == RTI_W'(RTI_CYCLES - 1)) state_next = S_RESP;
      S_RESP:  if (rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode. Every source register changes only while tck is low.
  always_comb begin
    vji_uir   = (state == S_UIR);
    vji_cdr   = (state == S_CDR);
    vji_sdr   = (state == S_SHIFT);
    vji_udr   = (state == S_UDR);
    vji_rti   = !((state == S_UIR) || (state == S_CDR) || (state == S_SHIFT) || (state == S_UDR));
    vji_tdi   = (state == S_SHIFT) ? data_sr[0] : 1'b0;
    vji_tck   = tck_q;
    vji_ir_in = ir_q;
    cmd_ready = (state == S_IDLE);
    rsp_valid = (state == S_RESP);
    rsp_data  = cap_sr;
  end

  // TCK generator: the half-period counter runs only while a scan is in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      tck_q   <= 1'b0;
    end else if (!busy) begin
      div_cnt <= '0;
      tck_q   <= 1'b0;
    end else if (half_end) begin
      div_cnt <= '0;
      tck_q   <= ~tck_q;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Command latch, TDI shifter, TDO capture and the shift and RTI period counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_sr <= '0;
      cap_sr  <= '0;
      ir_q    <= '0;
      bit_cnt <= '0;
      rti_cnt <= '0;
    end else begin
      if (accept) begin
        data_sr <= cmd_data;
        ir_q    <= cmd_ir;
      end else if (state == S_SHIFT && period_end) begin
        data_sr <= data_sr >> 1;
      end
      if (state == S_SHIFT && tck_rise)
        cap_sr <= {vji_tdo, cap_sr[DR_WIDTH-1:1]};
      if (state == S_CDR && period_end)
        bit_cnt <= '0;
      else if (state == S_SHIFT && period_end)
        bit_cnt <= bit_cnt + SH_W'(1);
      if (state == S_UDR && period_end)
        rti_cnt <= '0;
      else if (state == S_RTI && period_end)
        rti_cnt <= rti_cnt + RTI_W'(1);
    end
  end

`ifdef DEBUG_SCAN_IR_CAPTURE_EN
  logic [IR_WIDTH-1:0] ir_cap;

  // Slave IR status captured on the rising TCK of UIR; held until the next scan's capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       ir_cap <= '0;
    else if (state == S_UIR && tck_rise) ir_cap <= vji_ir_out;
  end

  assign rsp_ir_out = ir_cap;
`else
  logic unused_ir_out;
  assign unused_ir_out = ^vji_ir_out;
  assign rsp_ir_out    = '0;
`endif

endmodule
